nv_nvdla_cacc_group_ctrl: RTL and testbench
===========================================

// Module: nv_nvdla_cacc_group_ctrl
// PURPOSE
//  Consumer-side ping-pong controller for the two CACC register groups.
//  - Takes the SW producer pointer and op-enable set pulses; owns the consumer pointer.
//  - Drives the per-group 2-bit status fields back into the single-register file.
//  - Launches and retires layers on the CACC datapath and raises a done interrupt per group.
// PARAMETERS
//  RESTART_GAP  1   cycles dp_op_en stays low between back-to-back layers (legal range 1..15)
//  CNT_W        16  width of the per-group layer-done counters (wrap at 2^CNT_W)
// PORTS
//  nvdla_core_clk   in   1      core clock
//  nvdla_core_rstn  in   1      async active-low reset
//  producer         in   1      SW group pointer; selects the group op_en_set targets
//  op_en_set        in   1      1-cycle pulse: SW wrote 1 to D_OP_ENABLE of group [producer]
//  op_done          in   1      1-cycle pulse from datapath: current layer finished
//  consumer         out  1      group currently owned by HW
//  status_0         out  2      group 0 status: 0 IDLE, 1 RUNNING, 2 PENDING (3 never driven)
//  status_1         out  2      group 1 status, same encoding
//  op_en_0          out  1      group 0 op-enable register (readback)
//  op_en_1          out  1      group 1 op-enable register (readback)
//  dp_op_en         out  1      layer-active enable to datapath, configured from group [consumer]
//  done_intr        out  2      1-cycle interrupt pulse; bit g = group g retired
//  done_cnt_0       out  CNT_W  layers retired from group 0
//  done_cnt_1       out  CNT_W  layers retired from group 1
// BEHAVIOUR
//  Reset (async, active-low): every output is 0; gap counter 0; FSM in IDLE.
//  - Reset mid-layer abandons the layer silently: no done_intr, no counter update.
//  op_en set: on op_en_set, op_en[producer] <= 1 next edge.
//  - Pulse into an already-set group: no effect.
//  - SW cannot clear op_en; only HW retire clears it.
//  Status (combinational from flops):
//  - IDLE if op_en_g = 0.
//  - RUNNING if op_en_g = 1 and consumer == g.
//  - PENDING if op_en_g = 1 and consumer != g.
//  FSM states: IDLE, RUN, GAP.
//  - IDLE: if op_en[consumer] = 1, go to RUN. dp_op_en rises on the next edge (1-cycle launch latency).
//  - RUN (dp_op_en = 1): on op_done, all of the following happen at the same edge:
//    - op_en[consumer] <= 0
//    - done_intr[consumer] <= 1 for exactly one cycle
//    - done_cnt[consumer] += 1 (mod 2^CNT_W)
//    - consumer <= ~consumer
//    - dp_op_en <= 0
//    - go to GAP, load gap counter with RESTART_GAP - 1
//  - GAP: count down. At 0, go to IDLE.
//  Minimum dp_op_en low time between layers = RESTART_GAP + 1 cycles.
//  Simultaneous events:
//  - op_en_set targets the retiring group in the op_done cycle: set wins. The group ends with op_en = 1 and shows PENDING.
//  - op_en_set in the same cycle IDLE samples op_en[consumer]: the new value is seen one cycle later.
//  - op_done while not in RUN: ignored, no state change; flagged by a bench assertion.
//  - op_done in the launch cycle (IDLE->RUN edge): ignored.
//  Invariants:
//  - consumer changes only on retire.
//  - At most one done_intr bit is high in any cycle.
//  - status == 3 never occurs.
// TESTING
//  1. Reset, producer=0, pulse op_en_set at cycle 2.
//     -> op_en_0=1 and status_0=1 at cycle 3; dp_op_en=1 at cycle 4.
//  2. Running grp0, producer=1, pulse op_en_set.
//     -> status_1=2 (PENDING). Then op_done -> done_intr=2'b01 for one cycle, consumer=1,
//        status_0=0, status_1=1; dp_op_en low 2 cycles (RESTART_GAP=1), then high.
//  3. op_done and op_en_set with producer=0 in the same cycle while grp0 runs.
//     -> op_en_0 stays 1, status_0=2, consumer=1, done_cnt_0 += 1.
//  4. Pulse op_done with no layer enabled.
//     -> no outputs change; assertion fires.
//  5. Preload done_cnt_0 to 16'hFFFF via 65535 layers (or force), then retire one layer.
//     -> done_cnt_0 = 0.
//  6. Assert nvdla_core_rstn low mid-RUN.
//     -> all outputs 0 immediately; no done_intr after release.

Source files
------------

// File: rtl/nv_nvdla_cacc_group_ctrl.sv
// Consumer-side ping-pong controller for the two CACC register groups.
// Owns the consumer pointer, launches/retires layers and reports per-group status.
//
// state | meaning
// IDLE  | waiting for op_en of the consumer group
// RUN   | layer active on the datapath (dp_op_en high)
// GAP   | enforced dp_op_en low time after a retire
module nv_nvdla_cacc_group_ctrl #(
  parameter int RESTART_GAP = 1,
  parameter int CNT_W       = 16
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             producer,
  input  logic             op_en_set,
  input  logic             op_done,
  output logic             consumer,
  output logic [1:0]       status_0,
  output logic [1:0]       status_1,
  output logic             op_en_0,
  output logic             op_en_1,
  output logic             dp_op_en,
  output logic [1:0]       done_intr,
  output logic [CNT_W-1:0] done_cnt_0,
  output logic [CNT_W-1:0] done_cnt_1
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(RESTART_GAP - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] gap_cnt;
  logic [3:0] gap_cnt_nxt;
  logic [1:0] op_en;
  logic [1:0] op_en_nxt;
  logic       retire;

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    retire      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (op_en[consumer]) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (op_done) begin
          retire      = 1'b1;
          state_nxt   = ST_GAP;
          gap_cnt_nxt = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_cnt == 4'd0) state_nxt = ST_IDLE;
        else                 gap_cnt_nxt = gap_cnt - 4'd1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A set pulse into the retiring group overrides the retire clear.
  always_comb begin
    op_en_nxt = op_en;
    if (retire)    op_en_nxt[consumer] = 1'b0;
    if (op_en_set) op_en_nxt[producer] = 1'b1;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state      <= ST_IDLE;
      gap_cnt    <= 4'd0;
      op_en      <= 2'b00;
      consumer   <= 1'b0;
      dp_op_en   <= 1'b0;
      done_intr  <= 2'b00;
      done_cnt_0 <= '0;
      done_cnt_1 <= '0;
    end else begin
      state     <= state_nxt;
      gap_cnt   <= gap_cnt_nxt;
      op_en     <= op_en_nxt;
      dp_op_en  <= (state_nxt == ST_RUN);
      done_intr <= 2'b00;
      if (retire) begin
        consumer <= ~consumer;
        if (consumer) begin
          done_intr  <= 2'b10;
          done_cnt_1 <= done_cnt_1 + CNT_W'(1);
        end else begin
          done_intr  <= 2'b01;
          done_cnt_0 <= done_cnt_0 + CNT_W'(1);
        end
      end
    end
  end

  assign op_en_0  = op_en[0];
  assign op_en_1  = op_en[1];
  assign status_0 = !op_en[0] ? 2'd0 : (consumer == 1'b0 ? 2'd1 : 2'd2);
  assign status_1 = !op_en[1] ? 2'd0 : (consumer == 1'b1 ? 2'd1 : 2'd2);

endmodule

// File: tb/tb_nv_nvdla_cacc_group_ctrl.sv
// Bench for nv_nvdla_cacc_group_ctrl: directed vector table, random traffic against
// a layer-level model, and a mid-layer reset; a narrow-counter copy exercises wrap.
module tb_nv_nvdla_cacc_group_ctrl;

  logic clk = 1'b0;
  logic rstn;
  logic producer, op_en_set, op_done;

  logic        cons_a, oe0_a, oe1_a, dp_a;
  logic [1:0]  s0_a, s1_a, intr_a;
  logic [15:0] c0_a, c1_a;
  logic        cons_b, oe0_b, oe1_b, dp_b;
  logic [1:0]  s0_b, s1_b, intr_b;
  logic [2:0]  c0_b, c1_b;

  int errors = 0;
  int checks = 0;
  int stray  = 0;

  always #5 clk = ~clk;

  nv_nvdla_cacc_group_ctrl #(.RESTART_GAP(1), .CNT_W(16)) dut_a (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .producer(producer),
    .op_en_set(op_en_set), .op_done(op_done), .consumer(cons_a),
    .status_0(s0_a), .status_1(s1_a), .op_en_0(oe0_a), .op_en_1(oe1_a),
    .dp_op_en(dp_a), .done_intr(intr_a), .done_cnt_0(c0_a), .done_cnt_1(c1_a));

  nv_nvdla_cacc_group_ctrl #(.RESTART_GAP(3), .CNT_W(3)) dut_b (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .producer(producer),
    .op_en_set(op_en_set), .op_done(op_done), .consumer(cons_b),
    .status_0(s0_b), .status_1(s1_b), .op_en_0(oe0_b), .op_en_1(oe1_b),
    .dp_op_en(dp_b), .done_intr(intr_b), .done_cnt_0(c0_b), .done_cnt_1(c1_b));

  // Layer-level model: a layer is either active or not; after a retire the
  // controller is deaf for 'hold' edges before it samples op_en again.
  typedef struct {
    bit [1:0]    oe;
    bit          cons;
    bit          act;
    int          hold;
    int unsigned cnt0;
    int unsigned cnt1;
    bit [1:0]    intr;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mstep(mdl_t m, bit set, bit prod, bit done, int gap);
    mdl_t n = m;
    n.intr = 2'b00;
    if (m.act && done) begin
      n.intr[m.cons] = 1'b1;
      if (m.cons) n.cnt1 = m.cnt1 + 1;
      else        n.cnt0 = m.cnt0 + 1;
      n.oe[m.cons] = 1'b0;
      n.cons = ~m.cons;
      n.act  = 1'b0;
      n.hold = gap;
    end else if (!m.act) begin
      if (m.hold > 0)          n.hold = m.hold - 1;
      else if (m.oe[m.cons])   n.act  = 1'b1;
    end
    if (set) n.oe[prod] = 1'b1;
    return n;
  endfunction

  function automatic int stat(bit oe, bit cons, bit g);
    return !oe ? 0 : (cons == g ? 1 : 2);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(bit s, bit p, bit d);
    op_en_set = s;
    producer  = p;
    op_done   = d;
    @(posedge clk);
    #1;
    if (d && !ma.act) stray++;
    ma = mstep(ma, s, p, d, 1);
    mb = mstep(mb, s, p, d, 3);
    op_en_set = 1'b0;
    op_done   = 1'b0;
  endtask

  task automatic chk_models();
    chk("a_cons", int'(cons_a), int'(ma.cons));
    chk("a_oe", int'({oe1_a, oe0_a}), int'(ma.oe));
    chk("a_s0", int'(s0_a), stat(ma.oe[0], ma.cons, 1'b0));
    chk("a_s1", int'(s1_a), stat(ma.oe[1], ma.cons, 1'b1));
    chk("a_dp", int'(dp_a), int'(ma.act));
    chk("a_intr", int'(intr_a), int'(ma.intr));
    chk("a_cnt0", int'(c0_a), int'(ma.cnt0 % 65536));
    chk("a_cnt1", int'(c1_a), int'(ma.cnt1 % 65536));
    chk("b_cons", int'(cons_b), int'(mb.cons));
    chk("b_oe", int'({oe1_b, oe0_b}), int'(mb.oe));
    chk("b_s0", int'(s0_b), stat(mb.oe[0], mb.cons, 1'b0));
    chk("b_s1", int'(s1_b), stat(mb.oe[1], mb.cons, 1'b1));
    chk("b_dp", int'(dp_b), int'(mb.act));
    chk("b_intr", int'(intr_b), int'(mb.intr));
    chk("b_cnt0", int'(c0_b), int'(mb.cnt0 % 8));
    chk("b_cnt1", int'(c1_b), int'(mb.cnt1 % 8));
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_a_outs"}, int'({cons_a, s0_a, s1_a, oe0_a, oe1_a, dp_a, intr_a}), 0);
    chk({tag, "_a_cnts"}, int'({c0_a, c1_a}), 0);
    chk({tag, "_b_outs"}, int'({cons_b, s0_b, s1_b, oe0_b, oe1_b, dp_b, intr_b, c0_b, c1_b}), 0);
  endtask

  typedef struct {
    bit       set, prod, done;
    bit       cons, oe0, oe1, dp;
    bit [1:0] intr;
  } vec_t;

  vec_t vecs[20];

  initial begin
    // set prod done | cons oe0 oe1 dp intr  (expected after the edge, RESTART_GAP=1)
    vecs[0]  = '{0,0,0, 0,0,0,0,2'b00};
    vecs[1]  = '{1,0,0, 0,1,0,0,2'b00};  // op_en_0 set, RUNNING
    vecs[2]  = '{0,0,0, 0,1,0,1,2'b00};  // launch latency one cycle
    vecs[3]  = '{1,1,0, 0,1,1,1,2'b00};  // group 1 PENDING
    vecs[4]  = '{0,0,1, 1,0,1,0,2'b01};  // retire grp0
    vecs[5]  = '{0,0,0, 1,0,1,0,2'b00};
    vecs[6]  = '{0,0,0, 1,0,1,1,2'b00};  // low for exactly 2 cycles
    vecs[7]  = '{1,0,0, 1,1,1,1,2'b00};
    vecs[8]  = '{0,0,1, 0,1,0,0,2'b10};  // retire grp1
    vecs[9]  = '{0,0,0, 0,1,0,0,2'b00};
    vecs[10] = '{0,0,0, 0,1,0,1,2'b00};
    vecs[11] = '{1,0,1, 1,1,0,0,2'b01};  // set wins over retire clear
    vecs[12] = '{0,0,0, 1,1,0,0,2'b00};
    vecs[13] = '{0,0,0, 1,1,0,0,2'b00};  // consumer group not enabled
    vecs[14] = '{0,0,1, 1,1,0,0,2'b00};  // stray op_done ignored
    vecs[15] = '{1,1,0, 1,1,1,0,2'b00};
    vecs[16] = '{0,0,1, 1,1,1,1,2'b00};  // op_done in launch cycle ignored
    vecs[17] = '{0,0,1, 0,1,0,0,2'b10};
    vecs[18] = '{0,0,0, 0,1,0,0,2'b00};
    vecs[19] = '{0,0,0, 0,1,0,1,2'b00};

    rstn = 1'b0; producer = 1'b0; op_en_set = 1'b0; op_done = 1'b0;
    ma = '{default: 0};
    mb = '{default: 0};
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].set, vecs[i].prod, vecs[i].done);
      chk($sformatf("v%0d_cons", i), int'(cons_a), int'(vecs[i].cons));
      chk($sformatf("v%0d_oe", i), int'({oe1_a, oe0_a}), int'({vecs[i].oe1, vecs[i].oe0}));
      chk($sformatf("v%0d_s0", i), int'(s0_a), stat(vecs[i].oe0, vecs[i].cons, 1'b0));
      chk($sformatf("v%0d_s1", i), int'(s1_a), stat(vecs[i].oe1, vecs[i].cons, 1'b1));
      chk($sformatf("v%0d_dp", i), int'(dp_a), int'(vecs[i].dp));
      chk($sformatf("v%0d_intr", i), int'(intr_a), int'(vecs[i].intr));
      chk_models();
    end
    chk("tbl_cnt0", int'(c0_a), 2);
    chk("tbl_cnt1", int'(c1_a), 2);
    chk("stray_done_seen", stray, 2);

    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
      chk_models();
    end
    chk("wrap_exercised", int'(mb.cnt0 + mb.cnt1 >= 8), 1);

    // Drive into a running layer, then pull reset between edges.
    for (int i = 0; i < 40 && !ma.act; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      chk_models();
    end
    chk("reach_run", int'(dp_a), 1);
    rstn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #1;
    rstn = 1'b1;
    ma = '{default: 0};
    mb = '{default: 0};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, i == 1);
      chk_models();
      chk("post_rst_intr", int'({intr_a, intr_b}), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
